collision_scheduler: RTL and testbench
======================================

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT for calc_done before the pair is aborted.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 frame_start  in  1  one-cycle pulse per video frame (vsync rising edge, already synchronised to clk).
REQ-005 pair_req  in  10  overlap flag per ball pair; index map 0:(1,2) 1:(1,3) 2:(1,4) 3:(1,5) 4:(2,3) 5:(2,4) 6:(2,5) 7:(3,4) 8:(3,5) 9:(4,5).
REQ-006 ball_pocketed  in  5  bit i-1 set = ball i pocketed.
REQ-007 wall_hit_any  in  5  bit i-1 set = ball i in wall contact this frame.
REQ-008 calc_start  out  1  one-cycle request to the shared collision calculator.
REQ-009 calc_ball_a, calc_ball_b  out  3 each  ball numbers (1..5) of the issued pair, a < b.
REQ-010 calc_done  in  1  one-cycle completion from calculator.
REQ-011 calc_xa, calc_ya, calc_xb, calc_yb  in  11 signed each  post-collision speeds from calculator.
REQ-012 res_valid  out  1  one-cycle strobe; res_pair and res_* valid.
REQ-013 res_pair  out  4  pair index of result; res_xa, res_ya, res_xb, res_yb  out  11 signed each.
REQ-014 coll_mask  out  10  pairs resolved in the last completed frame; stable between frame_done pulses.
REQ-015 frame_done  out  1  one-cycle pulse when the frame scan ends.
REQ-016 overrun  out  1  sticky: frame_start arrived before frame_done.
REQ-017 timeout_err  out  1  sticky: a pair hit TIMEOUT_CYCLES.

Function
REQ-018 States IDLE, SCAN, ISSUE, WAIT, DONE; IDLE waits for frame_start.
REQ-019 On frame_start in IDLE: snapshot pair_req, ball_pocketed, wall_hit_any; clear claimed[4:0], working mask and pairs-examined counter; set scan index = rr_ptr; go SCAN.
REQ-020 SCAN examines one pair per cycle; pair eligible iff snapshot req set, neither ball pocketed, neither ball wall-hit, neither ball claimed.
REQ-021 Eligible pair: go ISSUE; ineligible: index = (index+1) mod 10, counter+1; after 10 pairs examined go DONE.
REQ-022 ISSUE: calc_start=1 for exactly one cycle with calc_ball_a/b driven; calc_ball_a/b held until WAIT exits; go WAIT.
REQ-023 WAIT: on calc_done register calc_* into res_*, pulse res_valid next cycle, set working-mask bit, claim both balls, advance index/counter, return SCAN.
REQ-024 WAIT cycle counter reaching TIMEOUT_CYCLES without calc_done: set timeout_err, no result, no claim, advance, return SCAN; a later stray calc_done ignored.
REQ-025 DONE: coll_mask <= working mask, frame_done pulse one cycle, rr_ptr <= (rr_ptr+1) mod 10 (wrap 9->0), go IDLE.
REQ-026 frame_start in any non-IDLE state: set overrun, abandon frame (no frame_done, coll_mask unchanged, rr_ptr unchanged), restart per REQ-019 with new snapshot; calc_done in the same cycle discarded.
REQ-027 Inputs changing mid-frame have no effect; only the snapshot is used.
REQ-028 At most one result per ball per frame; with conflicting pairs the first eligible from rr_ptr wins.

Reset
REQ-029 reset forces IDLE, rr_ptr=0, claimed=0, coll_mask=0, all res_*=0, res_valid=0, calc_start=0, calc_ball_a/b=0, frame_done=0, overrun=0, timeout_err=0; reset dominates frame_start and calc_done.
REQ-030 reset mid-WAIT discards the outstanding calculation.

Structure
REQ-031 Shared package holds pair-index to (ball_a, ball_b) table, NUM_PAIRS=10, NUM_BALLS=5, state encoding, speed width 11.
REQ-032 Single module; no sub-modules; shared calculator instantiated externally.

Verification
REQ-033 pair_req=10'h001, calc_done 5 cycles after calc_start with xa=3 ya=-2 xb=-3 yb=2 -> one calc_start balls (1,2), res_valid with res_pair=0 and those values, frame_done, coll_mask=10'h001.
REQ-034 pair_req=10'h003 (pairs 0,1 share ball 1), rr_ptr=0 -> only pair 0 issued; next frame same req, rr_ptr=1 -> only pair 1 issued.
REQ-035 pair_req=10'h081, ball 2 pocketed -> pair 0 skipped, pair 7 (3,4) issued, coll_mask=10'h080.
REQ-036 pair_req=10'h200, calc_done never asserted -> timeout_err set after 64 WAIT cycles, frame_done, coll_mask=0.
REQ-037 calc_done withheld 2 frames while frame_start repeats -> overrun set, scan restarts, no frame_done for aborted frame.
REQ-038 reset asserted during WAIT with calc_done same cycle -> all outputs at reset values next cycle, no res_valid.

Source files
------------

// File: rtl/collision_scheduler_pkg.sv
// Shared constants, state encoding and the pair-index to ball-number table
// for the per-frame collision scheduler.
package collision_scheduler_pkg;

  localparam int unsigned NUM_PAIRS = 10;
  localparam int unsigned NUM_BALLS = 5;
  localparam int unsigned SPEED_W   = 11;
  localparam int unsigned PAIR_W    = 4;
  localparam int unsigned BALL_W    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef struct packed {
    logic [BALL_W-1:0] a;
    logic [BALL_W-1:0] b;
  } ball_pair_t;

  function automatic ball_pair_t pair_balls(input logic [PAIR_W-1:0] idx);
    ball_pair_t p;
    case (idx)
      4'd0:    p = '{a: 3'd1, b: 3'd2};
      4'd1:    p = '{a: 3'd1, b: 3'd3};
      4'd2:    p = '{a: 3'd1, b: 3'd4};
      4'd3:    p = '{a: 3'd1, b: 3'd5};
      4'd4:    p = '{a: 3'd2, b: 3'd3};
      4'd5:    p = '{a: 3'd2, b: 3'd4};
      4'd6:    p = '{a: 3'd2, b: 3'd5};
      4'd7:    p = '{a: 3'd3, b: 3'd4};
      4'd8:    p = '{a: 3'd3, b: 3'd5};
      4'd9:    p = '{a: 3'd4, b: 3'd5};
      default: p = '{a: 3'd0, b: 3'd0};
    endcase
    return p;
  endfunction

  // Bit (n-1) set for each ball n taking part in the pair.
  function automatic logic [NUM_BALLS-1:0] pair_mask(input logic [PAIR_W-1:0] idx);
    logic [NUM_BALLS-1:0] m;
    case (idx)
      4'd0:    m = 5'b00011;
      4'd1:    m = 5'b00101;
      4'd2:    m = 5'b01001;
      4'd3:    m = 5'b10001;
      4'd4:    m = 5'b00110;
      4'd5:    m = 5'b01010;
      4'd6:    m = 5'b10010;
      4'd7:    m = 5'b01100;
      4'd8:    m = 5'b10100;
      4'd9:    m = 5'b11000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/collision_scheduler.sv
// Once per frame, walks the ball pairs round-robin and issues each eligible pair
// to an external shared collision calculator, one ball claim per frame.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [NUM_PAIRS-1:0]      pair_req,
  input  logic [NUM_BALLS-1:0]      ball_pocketed,
  input  logic [NUM_BALLS-1:0]      wall_hit_any,
  output logic                      calc_start,
  output logic [BALL_W-1:0]         calc_ball_a,
  output logic [BALL_W-1:0]         calc_ball_b,
  input  logic                      calc_done,
  input  logic signed [SPEED_W-1:0] calc_xa,
  input  logic signed [SPEED_W-1:0] calc_ya,
  input  logic signed [SPEED_W-1:0] calc_xb,
  input  logic signed [SPEED_W-1:0] calc_yb,
  output logic                      res_valid,
  output logic [PAIR_W-1:0]         res_pair,
  output logic signed [SPEED_W-1:0] res_xa,
  output logic signed [SPEED_W-1:0] res_ya,
  output logic signed [SPEED_W-1:0] res_xb,
  output logic signed [SPEED_W-1:0] res_yb,
  output logic [NUM_PAIRS-1:0]      coll_mask,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state;
  logic [PAIR_W-1:0]    rr_ptr;
  logic [PAIR_W-1:0]    scan_idx;
  logic [PAIR_W-1:0]    exam_cnt;
  logic [NUM_BALLS-1:0] claimed;
  logic [NUM_BALLS-1:0] snap_pocket;
  logic [NUM_BALLS-1:0] snap_wall;
  logic [NUM_PAIRS-1:0] snap_req;
  logic [NUM_PAIRS-1:0] work_mask;
  logic [WaitW-1:0]     wait_cnt;

  ball_pair_t           cur_pair;
  logic [NUM_BALLS-1:0] cur_mask;
  logic                 eligible;
  logic [PAIR_W-1:0]    next_idx;
  logic [PAIR_W-1:0]    next_rr;

  always_comb begin
    cur_pair = pair_balls(scan_idx);
    cur_mask = pair_mask(scan_idx);
    eligible = snap_req[scan_idx] &&
               (((snap_pocket | snap_wall | claimed) & cur_mask) == '0);
    next_idx = (scan_idx == PAIR_W'(NUM_PAIRS - 1)) ? '0 : scan_idx + 4'd1;
    next_rr  = (rr_ptr == PAIR_W'(NUM_PAIRS - 1)) ? '0 : rr_ptr + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      rr_ptr      <= '0;
      scan_idx    <= '0;
      exam_cnt    <= '0;
      claimed     <= '0;
      snap_pocket <= '0;
      snap_wall   <= '0;
      snap_req    <= '0;
      work_mask   <= '0;
      wait_cnt    <= '0;
      calc_start  <= 1'b0;
      calc_ball_a <= '0;
      calc_ball_b <= '0;
      res_valid   <= 1'b0;
      res_pair    <= '0;
      res_xa      <= '0;
      res_ya      <= '0;
      res_xb      <= '0;
      res_yb      <= '0;
      coll_mask   <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      res_valid  <= 1'b0;
      frame_done <= 1'b0;

      // A new frame always restarts the scan; outside IDLE it also drops the
      // current frame, including any calc_done arriving in the same cycle.
      if (frame_start) begin
        if (state != StIdle) overrun <= 1'b1;
        snap_req    <= pair_req;
        snap_pocket <= ball_pocketed;
        snap_wall   <= wall_hit_any;
        claimed     <= '0;
        work_mask   <= '0;
        exam_cnt    <= '0;
        scan_idx    <= rr_ptr;
        state       <= StScan;
      end else begin
        unique case (state)
          StIdle: ;
          StScan: begin
            if (exam_cnt == PAIR_W'(NUM_PAIRS)) begin
              state <= StDone;
            end else if (eligible) begin
              calc_start  <= 1'b1;
              calc_ball_a <= cur_pair.a;
              calc_ball_b <= cur_pair.b;
              state       <= StIssue;
            end else begin
              scan_idx <= next_idx;
              exam_cnt <= exam_cnt + 4'd1;
            end
          end
          StIssue: begin
            wait_cnt <= '0;
            state    <= StWait;
          end
          StWait: begin
            if (calc_done) begin
              res_valid <= 1'b1;
              res_pair  <= scan_idx;
              res_xa    <= calc_xa;
              res_ya    <= calc_ya;
              res_xb    <= calc_xb;
              res_yb    <= calc_yb;
              work_mask <= work_mask | (NUM_PAIRS'(1) << scan_idx);
              claimed   <= claimed | cur_mask;
              scan_idx  <= next_idx;
              exam_cnt  <= exam_cnt + 4'd1;
              state     <= StScan;
            end else if (wait_cnt == WaitW'(TIMEOUT_CYCLES - 1)) begin
              timeout_err <= 1'b1;
              scan_idx    <= next_idx;
              exam_cnt    <= exam_cnt + 4'd1;
              state       <= StScan;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          StDone: begin
            coll_mask  <= work_mask;
            frame_done <= 1'b1;
            rr_ptr     <= next_rr;
            state      <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: a scripted calculator responder drives
// calc_done, outputs are sampled on the falling edge and compared to hand values.
module tb_collision_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic [9:0]         pair_req;
  logic [4:0]         ball_pocketed;
  logic [4:0]         wall_hit_any;
  logic               calc_start;
  logic [2:0]         calc_ball_a;
  logic [2:0]         calc_ball_b;
  logic               calc_done;
  logic signed [10:0] calc_xa, calc_ya, calc_xb, calc_yb;
  logic               res_valid;
  logic [3:0]         res_pair;
  logic signed [10:0] res_xa, res_ya, res_xb, res_yb;
  logic [9:0]         coll_mask;
  logic               frame_done;
  logic               overrun;
  logic               timeout_err;

  always #5 clk = ~clk;

  collision_scheduler #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .pair_req     (pair_req),
    .ball_pocketed(ball_pocketed),
    .wall_hit_any (wall_hit_any),
    .calc_start   (calc_start),
    .calc_ball_a  (calc_ball_a),
    .calc_ball_b  (calc_ball_b),
    .calc_done    (calc_done),
    .calc_xa      (calc_xa),
    .calc_ya      (calc_ya),
    .calc_xb      (calc_xb),
    .calc_yb      (calc_yb),
    .res_valid    (res_valid),
    .res_pair     (res_pair),
    .res_xa       (res_xa),
    .res_ya       (res_ya),
    .res_xb       (res_xb),
    .res_yb       (res_yb),
    .coll_mask    (coll_mask),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Free-running pulse counters.
  int cs_cnt = 0;
  int rv_cnt = 0;
  int fd_cnt = 0;
  always @(posedge clk) begin
    if (calc_start) cs_cnt++;
    if (res_valid)  rv_cnt++;
    if (frame_done) fd_cnt++;
  end

  int                 fr_starts, fr_results, fr_t_start, fr_t_to;
  logic               fr_done;
  logic [2:0]         fr_a, fr_b;
  logic [3:0]         fr_pair;
  logic signed [10:0] fr_xa, fr_ya, fr_xb, fr_yb;
  logic               seen;
  int                 fd0, rv0, cs0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one frame; inputs are scrambled right after the snapshot cycle.
  // delay > 0: calc_done follows each calc_start by that many cycles; else never.
  task automatic run_frame(input logic [9:0] req, input logic [4:0] pocket,
                           input logic [4:0] wall, input int delay, input int budget);
    int countdown;
    countdown     = -1;
    pair_req      = req;
    ball_pocketed = pocket;
    wall_hit_any  = wall;
    frame_start   = 1'b1;
    @(negedge clk);
    frame_start   = 1'b0;
    pair_req      = ~req;
    ball_pocketed = 5'h1f;
    wall_hit_any  = 5'h1f;
    fr_starts  = 0;
    fr_results = 0;
    fr_done    = 1'b0;
    fr_t_start = -1;
    fr_t_to    = -1;
    for (int c = 0; c < budget && !fr_done; c++) begin
      if (calc_start) begin
        fr_starts++;
        fr_a = calc_ball_a;
        fr_b = calc_ball_b;
        fr_t_start = c;
      end
      if (res_valid) begin
        fr_results++;
        fr_pair = res_pair;
        fr_xa = res_xa;
        fr_ya = res_ya;
        fr_xb = res_xb;
        fr_yb = res_yb;
      end
      if (timeout_err && fr_t_to < 0) fr_t_to = c;
      if (frame_done) fr_done = 1'b1;
      calc_done = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          calc_done = 1'b1;
          countdown = -1;
        end
      end
      if (calc_start && delay > 0) countdown = delay;
      @(negedge clk);
    end
    calc_done = 1'b0;
  endtask

  task automatic pulse_fs(input logic with_done);
    frame_start = 1'b1;
    calc_done   = with_done;
    @(negedge clk);
    frame_start = 1'b0;
    calc_done   = 1'b0;
  endtask

  task automatic wait_start(input int budget, output logic got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (calc_start) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    pair_req = '0;
    ball_pocketed = '0;
    wall_hit_any = '0;
    calc_done = 1'b0;
    calc_xa = 11'sd3;
    calc_ya = -11'sd2;
    calc_xb = -11'sd3;
    calc_yb = 11'sd2;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_calc_start", calc_start, 1'b0);
    check_eq("rst_ball_a", calc_ball_a, 3'd0);
    check_eq("rst_ball_b", calc_ball_b, 3'd0);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_res_xa", res_xa, 0);
    check_eq("rst_coll_mask", coll_mask, 10'h000);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_timeout", timeout_err, 1'b0);

    // Pairs 0 and 1 share ball 1: rr_ptr 0 picks pair 0, rr_ptr 1 picks pair 1.
    run_frame(10'h003, 5'h00, 5'h00, 3, 150);
    check_eq("rr0_done", fr_done, 1'b1);
    check_eq("rr0_starts", fr_starts, 1);
    check_eq("rr0_a", fr_a, 3'd1);
    check_eq("rr0_b", fr_b, 3'd2);
    check_eq("rr0_mask", coll_mask, 10'h001);
    check_eq("rr0_overrun", overrun, 1'b0);
    run_frame(10'h003, 5'h00, 5'h00, 3, 150);
    check_eq("rr1_done", fr_done, 1'b1);
    check_eq("rr1_starts", fr_starts, 1);
    check_eq("rr1_a", fr_a, 3'd1);
    check_eq("rr1_b", fr_b, 3'd3);
    check_eq("rr1_mask", coll_mask, 10'h002);

    // Single pair with calculator latency of 5 cycles (rr_ptr 2).
    run_frame(10'h001, 5'h00, 5'h00, 5, 150);
    check_eq("one_done", fr_done, 1'b1);
    check_eq("one_starts", fr_starts, 1);
    check_eq("one_a", fr_a, 3'd1);
    check_eq("one_b", fr_b, 3'd2);
    check_eq("one_results", fr_results, 1);
    check_eq("one_pair", fr_pair, 4'd0);
    check_eq("one_xa", fr_xa, 3);
    check_eq("one_ya", fr_ya, -2);
    check_eq("one_xb", fr_xb, -3);
    check_eq("one_yb", fr_yb, 2);
    check_eq("one_mask", coll_mask, 10'h001);

    // Ball 2 pocketed: pair 0 skipped, pair 7 (3,4) issued (rr_ptr 3).
    run_frame(10'h081, 5'b00010, 5'h00, 2, 150);
    check_eq("pock_starts", fr_starts, 1);
    check_eq("pock_a", fr_a, 3'd3);
    check_eq("pock_b", fr_b, 3'd4);
    check_eq("pock_mask", coll_mask, 10'h080);

    // Ball 1 on the wall: nothing eligible (rr_ptr 4).
    run_frame(10'h001, 5'h00, 5'b00001, 2, 150);
    check_eq("wall_done", fr_done, 1'b1);
    check_eq("wall_starts", fr_starts, 0);
    check_eq("wall_mask", coll_mask, 10'h000);

    // Disjoint pairs 9 and 0 both resolve; from rr_ptr 5 pair 9 comes first.
    calc_xa = 11'sd100;
    calc_yb = -11'sd1024;
    run_frame(10'h201, 5'h00, 5'h00, 1, 150);
    check_eq("two_starts", fr_starts, 2);
    check_eq("two_results", fr_results, 2);
    check_eq("two_last_pair", fr_pair, 4'd0);
    check_eq("two_xa", fr_xa, 100);
    check_eq("two_yb", fr_yb, -1024);
    check_eq("two_mask", coll_mask, 10'h201);

    // Calculator silent: timeout 64 WAIT cycles after issue (rr_ptr 6).
    run_frame(10'h200, 5'h00, 5'h00, 0, 250);
    check_eq("to_done", fr_done, 1'b1);
    check_eq("to_starts", fr_starts, 1);
    check_eq("to_a", fr_a, 3'd4);
    check_eq("to_b", fr_b, 3'd5);
    check_eq("to_results", fr_results, 0);
    check_eq("to_err", timeout_err, 1'b1);
    check_eq("to_latency", fr_t_to - fr_t_start, 65);
    check_eq("to_mask", coll_mask, 10'h000);

    // Overrun: two frames aborted mid-WAIT, the second with a colliding calc_done.
    pair_req = 10'h001;
    ball_pocketed = '0;
    wall_hit_any = '0;
    fd0 = fd_cnt;
    rv0 = rv_cnt;
    pulse_fs(1'b0);
    wait_start(50, seen);
    check_eq("ovr_start0", seen, 1'b1);
    repeat (3) @(negedge clk);
    pulse_fs(1'b0);
    check_eq("ovr_flag", overrun, 1'b1);
    wait_start(50, seen);
    check_eq("ovr_start1", seen, 1'b1);
    repeat (3) @(negedge clk);
    pulse_fs(1'b1);
    wait_start(50, seen);
    check_eq("ovr_start2", seen, 1'b1);
    check_eq("ovr_no_res", rv_cnt - rv0, 0);
    check_eq("ovr_no_fd", fd_cnt - fd0, 0);
    @(negedge clk);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (frame_done) seen = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("ovr_fin_done", seen, 1'b1);
    check_eq("ovr_fd_cnt", fd_cnt - fd0, 1);
    check_eq("ovr_rv_cnt", rv_cnt - rv0, 1);
    check_eq("ovr_mask", coll_mask, 10'h001);

    // Aborted frames leave rr_ptr alone: now 8, so pair 8 (3,5) beats pair 7.
    run_frame(10'h180, 5'h00, 5'h00, 2, 150);
    check_eq("rr8_starts", fr_starts, 1);
    check_eq("rr8_a", fr_a, 3'd3);
    check_eq("rr8_b", fr_b, 3'd5);
    check_eq("rr8_mask", coll_mask, 10'h100);

    // Reset during WAIT together with calc_done.
    pair_req = 10'h001;
    ball_pocketed = '0;
    wall_hit_any = '0;
    pulse_fs(1'b0);
    wait_start(50, seen);
    check_eq("rw_start", seen, 1'b1);
    repeat (2) @(negedge clk);
    rv0 = rv_cnt;
    reset = 1'b1;
    calc_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    calc_done = 1'b0;
    check_eq("rw_calc_start", calc_start, 1'b0);
    check_eq("rw_ball_a", calc_ball_a, 3'd0);
    check_eq("rw_ball_b", calc_ball_b, 3'd0);
    check_eq("rw_res_valid", res_valid, 1'b0);
    check_eq("rw_res_xa", res_xa, 0);
    check_eq("rw_res_pair", res_pair, 4'd0);
    check_eq("rw_coll_mask", coll_mask, 10'h000);
    check_eq("rw_frame_done", frame_done, 1'b0);
    check_eq("rw_overrun", overrun, 1'b0);
    check_eq("rw_timeout", timeout_err, 1'b0);
    cs0 = cs_cnt;
    repeat (6) @(negedge clk);
    check_eq("rw_no_res", rv_cnt - rv0, 0);
    check_eq("rw_idle", cs_cnt - cs0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
